// File: rtl/tomasulo_pkg.sv
// Shared definitions for the tomasulo core: opcode encodings, reorder
// buffer geometry and opcode classification helpers.
package tomasulo_pkg;

    localparam int ROB_DEPTH = 8;
    localparam int ROB_TAG_W = 3;
    localparam int DATA_W    = 16;
    localparam int REG_W     = 4;
    localparam int FUNC_W    = 4;

    localparam logic [FUNC_W-1:0] OP_ADD   = 4'b0000;
    localparam logic [FUNC_W-1:0] OP_SUB   = 4'b0001;
    localparam logic [FUNC_W-1:0] OP_MUL   = 4'b0010;
    localparam logic [FUNC_W-1:0] OP_DIV   = 4'b0011;
    localparam logic [FUNC_W-1:0] OP_LOAD  = 4'b0100;
    localparam logic [FUNC_W-1:0] OP_STORE = 4'b0101;
    localparam logic [FUNC_W-1:0] OP_BEQ   = 4'b0110;
    localparam logic [FUNC_W-1:0] OP_BNEQ  = 4'b0111;

    // Arithmetic ops and loads write an architectural register at retire.
    function automatic logic is_reg_write(input logic [FUNC_W-1:0] func);
        return func <= OP_LOAD;
    endfunction

    function automatic logic is_store(input logic [FUNC_W-1:0] func);
        return func == OP_STORE;
    endfunction

    function automatic logic is_branch(input logic [FUNC_W-1:0] func);
        return (func == OP_BEQ) || (func == OP_BNEQ);
    endfunction

endpackage

// File: rtl/rob_ptr.sv
// Wrap-around ring pointer used for the reorder buffer head and tail.
// Clear has priority over increment; the pointer wraps naturally because
// the ring depth is a power of two.
module rob_ptr #(
    parameter int W = 3
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         inc_i,
    input  logic         clr_i,
    output logic [W-1:0] ptr_o
);

    logic [W-1:0] ptr_q;
    logic [W-1:0] ptr_d;

    // Next pointer value: clear, advance, or hold.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
        ptr_d = ptr_q;
        if (clr_i) begin
            ptr_d = '0;
        end else if (inc_i) begin
            ptr_d = ptr_q + W'(1);
        end
    end

    // Pointer register with synchronous reset.
    always_ff @(posedge clk_i) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
        if (rst_i) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    assign ptr_o = ptr_q;

endmodule

// File: rtl/reorder_buffer.sv
// Reorder buffer: allocates entries in program order from issue, collects
// results from the CDB, and retires the head entry once its result is in,
// driving register writes, store release and mispredict flush.
module reorder_buffer #(
    parameter int DEPTH  = tomasulo_pkg::ROB_DEPTH,
    parameter int TAG_W  = tomasulo_pkg::ROB_TAG_W,
    parameter int DATA_W = tomasulo_pkg::DATA_W,
    parameter int REG_W  = tomasulo_pkg::REG_W
) (
    input  logic                            clk1,
    input  logic                            rst,
    // allocation from issue
    input  logic                            alloc_valid,
    input  logic [tomasulo_pkg::FUNC_W-1:0] alloc_func,
    input  logic [REG_W-1:0]                alloc_rd,
    output logic                            alloc_ready,
    output logic [TAG_W-1:0]                alloc_tag,
    // result broadcast
    input  logic                            cdb_valid,
    input  logic [TAG_W-1:0]                cdb_tag,
    input  logic [DATA_W-1:0]               cdb_data,
    input  logic                            cdb_mispred,
    // operand lookup
    input  logic [TAG_W-1:0]                src_tag_a,
    input  logic [TAG_W-1:0]                src_tag_b,
    output logic                            src_rdy_a,
    output logic                            src_rdy_b,
    output logic [DATA_W-1:0]               src_data_a,
    output logic [DATA_W-1:0]               src_data_b,
    // retirement
    output logic                            commit_valid,
    output logic [REG_W-1:0]                commit_rd,
    output logic                            commit_wen,
    output logic [DATA_W-1:0]               commit_data,
    output logic [TAG_W-1:0]                commit_tag,
    output logic                            commit_store,
    output logic                            commit_flush,
    output logic [TAG_W:0]                  count
);

    import tomasulo_pkg::*;

    localparam logic [TAG_W:0] FULL_COUNT = (TAG_W+1)'(DEPTH);
    localparam logic [TAG_W:0] CNT_ONE    = {{TAG_W{1'b0}}, 1'b1};

    // entry state: valid is the only field that needs a known reset value
    logic [DEPTH-1:0]  valid_q;
    logic [DEPTH-1:0]  done_q;
    logic [DEPTH-1:0]  mispred_q;
    logic [FUNC_W-1:0] func_q [DEPTH];
    logic [REG_W-1:0]  rd_q   [DEPTH];
    logic [DATA_W-1:0] data_q [DEPTH];

    logic [TAG_W:0]    count_q;
    logic [TAG_W:0]    count_d;
    logic [TAG_W-1:0]  head;
    logic [TAG_W-1:0]  tail;

    logic              head_ready;
    logic [FUNC_W-1:0] head_func;
    logic              flush;
    logic              accept;
    logic              cdb_hit;
    logic              bypass_a;
    logic              bypass_b;

    // ---------------- head retirement ----------------
    assign head_ready = valid_q[head] & done_q[head];
    assign head_func  = func_q[head];
    assign flush      = head_ready & is_branch(head_func) & mispred_q[head];

    assign commit_valid = head_ready;
    assign commit_flush = flush;
    assign commit_wen   = head_ready & is_reg_write(head_func) & ~flush;
    assign commit_store = head_ready & is_store(head_func);
    assign commit_rd    = head_ready ? rd_q[head]   : '0;
    assign commit_data  = head_ready ? data_q[head] : '0;
    assign commit_tag   = head_ready ? head         : '0;

    // ---------------- allocation ----------------
    // Readiness looks only at the registered count, so a slot freed by a
    // commit becomes usable on the following cycle.
    assign alloc_ready = (count_q != FULL_COUNT) & ~flush;
    assign accept      = alloc_valid & alloc_ready;
    assign alloc_tag   = tail;
    assign count       = count_q;

    // A broadcast only lands on a live entry; a flush discards it.
    assign cdb_hit = cdb_valid & valid_q[cdb_tag] & ~flush;

    // ---------------- pointers ----------------
    rob_ptr #(.W(TAG_W)) u_head (
        .clk_i (clk1),
        .rst_i (rst),
        .inc_i (head_ready & ~flush),
        .clr_i (flush),
        .ptr_o (head)
    );

    rob_ptr #(.W(TAG_W)) u_tail (
        .clk_i (clk1),
        .rst_i (rst),
        .inc_i (accept),
        .clr_i (flush),
        .ptr_o (tail)
    );

    // Occupancy: +1 on accept, -1 on commit, cleared by a flush.
    always_comb begin
        count_d = count_q;
        if (flush) begin
            count_d = '0;
        end else if (accept && !head_ready) begin
            count_d = count_q + CNT_ONE;
        end else if (head_ready && !accept) begin
            count_d = count_q - CNT_ONE;
        end
    end

    // Occupancy register.
    always_ff @(posedge clk1) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    // Entry valid bits: set on allocation, cleared on retire, reset or flush.
    always_ff @(posedge clk1) begin
        if (rst) begin
            valid_q <= '0;
        end else if (flush) begin
            valid_q <= '0;
        end else begin
            if (accept) begin
                valid_q[tail] <= 1'b1;
            end
            if (head_ready) begin
                valid_q[head] <= 1'b0;
            end
        end
    end

    // Entry payload: written on allocation and on CDB writeback.
    always_ff @(posedge clk1) begin
        // NOTE: the payload array has no reset; it is only observed through valid, which is reset.
        if (accept) begin
            done_q[tail] <= 1'b0;
            func_q[tail] <= alloc_func;
            rd_q[tail]   <= is_reg_write(alloc_func) ? alloc_rd : '0;
        end
        if (cdb_hit) begin
            done_q[cdb_tag]    <= 1'b1;
            data_q[cdb_tag]    <= cdb_data;
            mispred_q[cdb_tag] <= cdb_mispred;
        end
    end

    // ---------------- operand lookup with CDB bypass ----------------
    assign bypass_a   = cdb_valid & (cdb_tag == src_tag_a);
    assign bypass_b   = cdb_valid & (cdb_tag == src_tag_b);
    assign src_rdy_a  = bypass_a | (valid_q[src_tag_a] & done_q[src_tag_a]);
    assign src_rdy_b  = bypass_b | (valid_q[src_tag_b] & done_q[src_tag_b]);
    assign src_data_a = bypass_a ? cdb_data : data_q[src_tag_a];
    assign src_data_b = bypass_b ? cdb_data : data_q[src_tag_b];

    // A second result for an entry that already has one indicates an
    // upstream tag bookkeeping error.
    cdb_to_done_entry : assert property (
        @(posedge clk1) disable iff (rst) !(cdb_hit && done_q[cdb_tag])
    );

endmodule

// File: tb/tb_reorder_buffer.sv
// Self-checking bench for reorder_buffer: a directed vector table, a few
// hand-written multi-cycle sequences, and randomized traffic compared to a
// queue-based program-order model.
module tb_reorder_buffer;

    import tomasulo_pkg::*;

    logic        clk1 = 1'b0;
    logic        rst;
    logic        alloc_valid;
    logic [3:0]  alloc_func;
    logic [3:0]  alloc_rd;
    logic        alloc_ready;
    logic [2:0]  alloc_tag;
    logic        cdb_valid;
    logic [2:0]  cdb_tag;
    logic [15:0] cdb_data;
    logic        cdb_mispred;
    logic [2:0]  src_tag_a;
    logic [2:0]  src_tag_b;
    logic        src_rdy_a;
    logic        src_rdy_b;
    logic [15:0] src_data_a;
    logic [15:0] src_data_b;
    logic        commit_valid;
    logic [3:0]  commit_rd;
    logic        commit_wen;
    logic [15:0] commit_data;
    logic [2:0]  commit_tag;
    logic        commit_store;
    logic        commit_flush;
    logic [3:0]  count;

    reorder_buffer dut (
        .clk1         (clk1),
        .rst          (rst),
        .alloc_valid  (alloc_valid),
        .alloc_func   (alloc_func),
        .alloc_rd     (alloc_rd),
        .alloc_ready  (alloc_ready),
        .alloc_tag    (alloc_tag),
        .cdb_valid    (cdb_valid),
        .cdb_tag      (cdb_tag),
        .cdb_data     (cdb_data),
        .cdb_mispred  (cdb_mispred),
        .src_tag_a    (src_tag_a),
        .src_tag_b    (src_tag_b),
        .src_rdy_a    (src_rdy_a),
        .src_rdy_b    (src_rdy_b),
        .src_data_a   (src_data_a),
        .src_data_b   (src_data_b),
        .commit_valid (commit_valid),
        .commit_rd    (commit_rd),
        .commit_wen   (commit_wen),
        .commit_data  (commit_data),
        .commit_tag   (commit_tag),
        .commit_store (commit_store),
        .commit_flush (commit_flush),
        .count        (count)
    );

    always #5 clk1 = ~clk1;

    int tests = 0;
    int fails = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: actual=0x%0h expected=0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk1);
        #1;
    endtask

    task automatic drive_idle();
        rst         = 1'b0;
        alloc_valid = 1'b0;
        alloc_func  = OP_ADD;
        alloc_rd    = 4'd0;
        cdb_valid   = 1'b0;
        cdb_tag     = 3'd0;
        cdb_data    = 16'h0;
        cdb_mispred = 1'b0;
        src_tag_a   = 3'd0;
        src_tag_b   = 3'd0;
    endtask

    // ---------------- program-order reference model ----------------
    typedef struct {
        logic [2:0]  tag;
        logic [3:0]  func;
        logic [3:0]  rd;
        bit          done;
        logic [15:0] data;
        bit          mispred;
    } mentry_t;

    mentry_t mq[$];
    int      m_tail;

    function automatic int mfind(input logic [2:0] t);
        foreach (mq[i]) if (mq[i].tag == t) return i;
        return -1;
    endfunction

    task automatic model_reset();
        mq.delete();
        m_tail = 0;
    endtask

    function automatic bit lookup_rdy(input logic [2:0] t);
        int idx;
        idx = mfind(t);
        return (cdb_valid && cdb_tag == t) || (idx >= 0 && mq[idx].done);
    endfunction

    function automatic logic [15:0] lookup_data(input logic [2:0] t);
        int idx;
        idx = mfind(t);
        if (cdb_valid && cdb_tag == t) return cdb_data;
        return mq[idx].data;
    endfunction

    // Compare the DUT against the model for the inputs currently driven,
    // then advance both across one clock edge.
    task automatic model_cycle();
        bit      m_cv;
        bit      m_flush;
        bit      m_ready;
        bit      m_wen;
        int      idx;
        mentry_t e;
        #1;
        m_cv    = (mq.size() > 0) && mq[0].done;
        m_flush = m_cv && (mq[0].func == OP_BEQ || mq[0].func == OP_BNEQ) && mq[0].mispred;
        m_ready = (mq.size() < 8) && !m_flush;
        m_wen   = m_cv && (mq[0].func <= OP_LOAD);
        check("m.count",        32'(count),        32'(mq.size()));
        check("m.alloc_ready",  32'(alloc_ready),  32'(m_ready));
        check("m.alloc_tag",    32'(alloc_tag),    32'(m_tail));
        check("m.commit_valid", 32'(commit_valid), 32'(m_cv));
        check("m.commit_flush", 32'(commit_flush), 32'(m_flush));
        check("m.commit_wen",   32'(commit_wen),   32'(m_wen));
        check("m.commit_store", 32'(commit_store), 32'(m_cv && mq[0].func == OP_STORE));
        if (m_cv) begin
            check("m.commit_tag",  32'(commit_tag),  32'(mq[0].tag));
            check("m.commit_data", 32'(commit_data), 32'(mq[0].data));
        end
        if (m_wen) check("m.commit_rd", 32'(commit_rd), 32'(mq[0].rd));
        check("m.src_rdy_a", 32'(src_rdy_a), 32'(lookup_rdy(src_tag_a)));
        check("m.src_rdy_b", 32'(src_rdy_b), 32'(lookup_rdy(src_tag_b)));
        if (lookup_rdy(src_tag_a)) check("m.src_data_a", 32'(src_data_a), 32'(lookup_data(src_tag_a)));
        if (lookup_rdy(src_tag_b)) check("m.src_data_b", 32'(src_data_b), 32'(lookup_data(src_tag_b)));
        @(posedge clk1);
        if (rst || m_flush) begin
            model_reset();
        end else begin
            if (cdb_valid) begin
                idx = mfind(cdb_tag);
                if (idx >= 0) begin
                    e         = mq[idx];
                    e.done    = 1'b1;
                    e.data    = cdb_data;
                    e.mispred = cdb_mispred;
                    mq[idx]   = e;
                end
            end
            if (m_cv) void'(mq.pop_front());
            if (alloc_valid && m_ready) begin
                e = '{tag: 3'(m_tail), func: alloc_func, rd: alloc_rd, done: 1'b0, data: 16'h0, mispred: 1'b0};
                mq.push_back(e);
                m_tail = (m_tail + 1) % 8;
            end
        end
        #1;
    endtask

    // Random inputs; CDB only targets entries without a result yet, or tags
    // with no live entry.
    task automatic rand_inputs();
        logic [2:0] cand[$];
        int         idx;
        drive_idle();
        rst         = ($urandom_range(0, 199) == 0);
        alloc_valid = ($urandom_range(0, 9) < 6);
        alloc_func  = 4'($urandom_range(0, 7));
        alloc_rd    = 4'($urandom_range(0, 15));
        src_tag_a   = 3'($urandom_range(0, 7));
        src_tag_b   = 3'($urandom_range(0, 7));
        cdb_data    = 16'($urandom_range(0, 65535));
        if ($urandom_range(0, 9) < 6) begin
            for (int t = 0; t < 8; t++) begin
                idx = mfind(3'(t));
                if (idx < 0 || !mq[idx].done) cand.push_back(3'(t));
            end
            if (cand.size() > 0) begin
                cdb_valid = 1'b1;
                cdb_tag   = cand[$urandom_range(0, cand.size() - 1)];
                idx       = mfind(cdb_tag);
                if (idx >= 0 && (mq[idx].func == OP_BEQ || mq[idx].func == OP_BNEQ))
                    cdb_mispred = ($urandom_range(0, 2) == 0);
            end
        end
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        logic        av;
        logic [3:0]  func;
        logic [3:0]  rd;
        logic        cv;
        logic [2:0]  ctag;
        logic [15:0] cdata;
        logic        e_ready;
        logic [2:0]  e_atag;
        logic [3:0]  e_count;
        logic        e_cv;
        logic [2:0]  e_ctag;
        logic [15:0] e_cdata;
        logic [3:0]  e_crd;
        logic        e_wen;
    } vec_t;

    vec_t vecs[15];

    initial begin
        // fill: 8 allocs, a rejected 9th, out-of-order CDB, full-with-commit
        for (int i = 0; i < 8; i++)
            vecs[i] = '{1'b1, OP_ADD, 4'(i + 1), 1'b0, 3'd0, 16'h0,
                        1'b1, 3'(i), 4'(i), 1'b0, 3'd0, 16'h0, 4'd0, 1'b0};
        vecs[8]  = '{1'b1, OP_ADD, 4'd9, 1'b0, 3'd0, 16'h0000, 1'b0, 3'd0, 4'd8, 1'b0, 3'd0, 16'h0000, 4'd0, 1'b0};
        vecs[9]  = '{1'b0, OP_ADD, 4'd0, 1'b1, 3'd2, 16'h00AA, 1'b0, 3'd0, 4'd8, 1'b0, 3'd0, 16'h0000, 4'd0, 1'b0};
        vecs[10] = '{1'b0, OP_ADD, 4'd0, 1'b1, 3'd0, 16'h0011, 1'b0, 3'd0, 4'd8, 1'b0, 3'd0, 16'h0000, 4'd0, 1'b0};
        vecs[11] = '{1'b1, OP_ADD, 4'd9, 1'b1, 3'd1, 16'h0022, 1'b0, 3'd0, 4'd8, 1'b1, 3'd0, 16'h0011, 4'd1, 1'b1};
        vecs[12] = '{1'b1, OP_ADD, 4'd9, 1'b0, 3'd0, 16'h0000, 1'b1, 3'd0, 4'd7, 1'b1, 3'd1, 16'h0022, 4'd2, 1'b1};
        vecs[13] = '{1'b0, OP_ADD, 4'd0, 1'b0, 3'd0, 16'h0000, 1'b1, 3'd1, 4'd7, 1'b1, 3'd2, 16'h00AA, 4'd3, 1'b1};
        vecs[14] = '{1'b0, OP_ADD, 4'd0, 1'b0, 3'd0, 16'h0000, 1'b1, 3'd1, 4'd6, 1'b0, 3'd0, 16'h0000, 4'd0, 1'b0};

        drive_idle();
        rst = 1'b1;
        repeat (2) @(posedge clk1);
        #1;
        rst = 1'b0;
        #1;
        check("reset.alloc_ready",  32'(alloc_ready),  32'd1);
        check("reset.alloc_tag",    32'(alloc_tag),    32'd0);
        check("reset.count",        32'(count),        32'd0);
        check("reset.commit_valid", 32'(commit_valid), 32'd0);
        check("reset.commit_data",  32'(commit_data),  32'd0);
        check("reset.src_rdy_a",    32'(src_rdy_a),    32'd0);

        foreach (vecs[i]) begin
            drive_idle();
            alloc_valid = vecs[i].av;
            alloc_func  = vecs[i].func;
            alloc_rd    = vecs[i].rd;
            cdb_valid   = vecs[i].cv;
            cdb_tag     = vecs[i].ctag;
            cdb_data    = vecs[i].cdata;
            #1;
            check($sformatf("vec%0d.alloc_ready", i),  32'(alloc_ready),  32'(vecs[i].e_ready));
            check($sformatf("vec%0d.alloc_tag", i),    32'(alloc_tag),    32'(vecs[i].e_atag));
            check($sformatf("vec%0d.count", i),        32'(count),        32'(vecs[i].e_count));
            check($sformatf("vec%0d.commit_valid", i), 32'(commit_valid), 32'(vecs[i].e_cv));
            check($sformatf("vec%0d.commit_wen", i),   32'(commit_wen),   32'(vecs[i].e_wen));
            if (vecs[i].e_cv) begin
                check($sformatf("vec%0d.commit_tag", i),  32'(commit_tag),  32'(vecs[i].e_ctag));
                check($sformatf("vec%0d.commit_data", i), 32'(commit_data), 32'(vecs[i].e_cdata));
                check($sformatf("vec%0d.commit_rd", i),   32'(commit_rd),   32'(vecs[i].e_crd));
            end
            tick();
        end

        // reset with live entries plus a same-cycle alloc and CDB
        drive_idle();
        rst         = 1'b1;
        alloc_valid = 1'b1;
        cdb_valid   = 1'b1;
        cdb_tag     = 3'd3;
        cdb_data    = 16'hDEAD;
        tick();
        drive_idle();
        src_tag_a = 3'd3;
        #1;
        check("rst_mid.alloc_ready",  32'(alloc_ready),  32'd1);
        check("rst_mid.alloc_tag",    32'(alloc_tag),    32'd0);
        check("rst_mid.count",        32'(count),        32'd0);
        check("rst_mid.commit_valid", 32'(commit_valid), 32'd0);
        check("rst_mid.commit_wen",   32'(commit_wen),   32'd0);
        check("rst_mid.commit_flush", 32'(commit_flush), 32'd0);
        check("rst_mid.src_rdy_a",    32'(src_rdy_a),    32'd0);
        check("rst_mid.src_rdy_b",    32'(src_rdy_b),    32'd0);
        cdb_valid = 1'b1;
        cdb_tag   = 3'd3;
        cdb_data  = 16'hBEEF;
        tick();
        cdb_valid = 1'b0;
        #1;
        check("rst_mid.cdb_ignored", 32'(src_rdy_a), 32'd0);

        // mispredicted branch at the head flushes everything
        drive_idle();
        alloc_valid = 1'b1;
        alloc_func  = OP_BEQ;
        alloc_rd    = 4'd7;
        tick();
        alloc_func = OP_ADD;
        alloc_rd   = 4'd5;
        tick();
        alloc_func  = OP_MUL;
        alloc_rd    = 4'd6;
        cdb_valid   = 1'b1;
        cdb_tag     = 3'd0;
        cdb_data    = 16'h0001;
        cdb_mispred = 1'b1;
        tick();
        alloc_func  = OP_ADD;
        alloc_rd    = 4'd1;
        cdb_tag     = 3'd1;
        cdb_data    = 16'h5555;
        cdb_mispred = 1'b0;
        #1;
        check("flush.commit_valid", 32'(commit_valid), 32'd1);
        check("flush.commit_flush", 32'(commit_flush), 32'd1);
        check("flush.commit_wen",   32'(commit_wen),   32'd0);
        check("flush.commit_tag",   32'(commit_tag),   32'd0);
        check("flush.alloc_ready",  32'(alloc_ready),  32'd0);
        check("flush.count",        32'(count),        32'd3);
        tick();
        drive_idle();
        cdb_valid = 1'b1;
        cdb_tag   = 3'd1;
        cdb_data  = 16'h7777;
        #1;
        check("post_flush.count",        32'(count),        32'd0);
        check("post_flush.alloc_tag",    32'(alloc_tag),    32'd0);
        check("post_flush.alloc_ready",  32'(alloc_ready),  32'd1);
        check("post_flush.commit_valid", 32'(commit_valid), 32'd0);
        tick();
        drive_idle();
        src_tag_a = 3'd1;
        #1;
        check("post_flush.cdb_ignored",  32'(src_rdy_a),    32'd0);
        check("post_flush.count2",       32'(count),        32'd0);
        check("post_flush.commit_valid2", 32'(commit_valid), 32'd0);

        // same-cycle CDB bypass on the lookup ports
        for (int i = 0; i < 4; i++) begin
            drive_idle();
            alloc_valid = 1'b1;
            alloc_rd    = 4'(i);
            tick();
        end
        drive_idle();
        src_tag_a = 3'd3;
        src_tag_b = 3'd2;
        cdb_valid = 1'b1;
        cdb_tag   = 3'd3;
        cdb_data  = 16'h1234;
        #1;
        check("bypass.src_rdy_a",  32'(src_rdy_a),  32'd1);
        check("bypass.src_data_a", 32'(src_data_a), 32'h1234);
        check("bypass.src_rdy_b",  32'(src_rdy_b),  32'd0);
        tick();
        drive_idle();
        src_tag_a = 3'd3;
        #1;
        check("stored.src_rdy_a",    32'(src_rdy_a),    32'd1);
        check("stored.src_data_a",   32'(src_data_a),   32'h1234);
        check("stored.commit_valid", 32'(commit_valid), 32'd0);
        check("stored.count",        32'(count),        32'd4);

        // wrap: 12 alloc/commit pairs pipelined through the model
        drive_idle();
        rst = 1'b1;
        tick();
        model_reset();
        for (int i = 0; i < 14; i++) begin
            drive_idle();
            alloc_valid = (i < 12);
            alloc_rd    = 4'(i);
            if (i >= 1 && i <= 12) begin
                cdb_valid = 1'b1;
                cdb_tag   = 3'(i - 1);
                cdb_data  = 16'(16'h0100 + i);
            end
            model_cycle();
        end
        drive_idle();
        #1;
        check("wrap.drained", 32'(count), 32'd0);

        // randomized traffic against the model
        for (int n = 0; n < 800; n++) begin
            rand_inputs();
            model_cycle();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
